// File: rtl/sweep_scan_engine_if.sv
// Configuration, acquisition-data and status bundle of the threshold-DAC sweep engine.
interface sweep_scan_engine_if #(
  parameter int unsigned DAC_WIDTH = 10,
  parameter int unsigned CH_NUM    = 64,
  parameter int unsigned CNT_WIDTH = 16
);
  localparam int unsigned CH_W = $clog2(CH_NUM);

  logic                 SweepStart;
  logic                 SweepAbort;
  logic [DAC_WIDTH-1:0] StartDAC;
  logic [DAC_WIDTH-1:0] StopDAC;
  logic [DAC_WIDTH-1:0] StepDAC;
  logic [1:0]           DacSelect;
  logic                 ChannelSweep;
  logic [CH_W-1:0]      SingleChannel;
  logic [CNT_WIDTH-1:0] MaxPackageNumber;
  logic [15:0]          ParallelData;
  logic                 ParallelData_en;
  logic                 LoadDone;

  logic                 SingleACQStart;
  logic                 SingleACQStop;
  logic                 ACQDone;
  logic [DAC_WIDTH-1:0] OutDAC;
  logic [1:0]           OutDACSelect;
  logic [CH_W-1:0]      MaskChannel;
  logic                 LoadSCParameter;
  logic [15:0]          SweepACQData;
  logic                 SweepACQData_en;

  // Engine side.
  modport slave (
    input  SweepStart, SweepAbort, StartDAC, StopDAC, StepDAC, DacSelect, ChannelSweep,
           SingleChannel, MaxPackageNumber, ParallelData, ParallelData_en, LoadDone,
    output SingleACQStart, SingleACQStop, ACQDone, OutDAC, OutDACSelect, MaskChannel,
           LoadSCParameter, SweepACQData, SweepACQData_en
  );

  // Controller / data-source side.
  modport master (
    output SweepStart, SweepAbort, StartDAC, StopDAC, StepDAC, DacSelect, ChannelSweep,
           SingleChannel, MaxPackageNumber, ParallelData, ParallelData_en, LoadDone,
    input  SingleACQStart, SingleACQStop, ACQDone, OutDAC, OutDACSelect, MaskChannel,
           LoadSCParameter, SweepACQData, SweepACQData_en
  );
endinterface

// File: rtl/sweep_scan_engine.sv
// Threshold-DAC sweep engine: steps a DAC code (optionally over all channels), triggers one
// acquisition per point and frames the forwarded data with header/parameter/tail words.
module sweep_scan_engine #(
  parameter int unsigned DAC_WIDTH = 10,
  parameter int unsigned CH_NUM    = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic               Clk,
  input  logic               reset_n,
  sweep_scan_engine_if.slave bus
);
  localparam int unsigned     CH_W   = $clog2(CH_NUM);
  localparam logic [CH_W-1:0] LastCh = CH_W'(CH_NUM - 1);

  typedef enum logic [3:0] {
    StIdle, StHeader, StParamA, StParamB, StLoadSc, StWaitLoad,
    StStartAcq, StAcq, StNextPoint, StTail, StDone
  } state_e;

  state_e               state_q, state_d;
  logic                 sweep_start_q;
  logic [DAC_WIDTH-1:0] start_dac_q, start_dac_d, stop_dac_q, stop_dac_d, step_q, step_d;
  logic [DAC_WIDTH-1:0] code_q, code_d;
  logic [1:0]           sel_q, sel_d;
  logic                 chsweep_q, chsweep_d, asc_q, asc_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [CNT_WIDTH-1:0] max_q, max_d, cnt_q, cnt_d;
  logic [15:0]          data_q, data_d;
  logic                 data_en_q, data_en_d, load_q, load_d;
  logic                 acq_start_q, acq_start_d, acq_stop_q, acq_stop_d;

  logic                 start_edge, abort;
  logic [DAC_WIDTH-1:0] remain;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [9:0]           code10;
  logic [5:0]           ch6;

  assign start_edge = bus.SweepStart & ~sweep_start_q;
  assign abort      = bus.SweepAbort & ~(state_q inside {StIdle, StTail, StDone});
  assign cnt_inc    = cnt_q + 1'b1;
  // Distance still left to the stop code; the code never passes stop, so no wrap.
  assign remain     = asc_q ? (stop_dac_q - code_q) : (code_q - stop_dac_q);

  // Zero-extend code and channel into the fixed-width parameter-word fields.
  always_comb begin
    code10 = '0;
    code10[DAC_WIDTH-1:0] = code_q;
    ch6 = '0;
    ch6[CH_W-1:0] = ch_q;
  end

  // Next-state, configuration latch and registered-output decode.
  always_comb begin
    state_d     = state_q;
    start_dac_d = start_dac_q;
    stop_dac_d  = stop_dac_q;
    step_d      = step_q;
    sel_d       = sel_q;
    chsweep_d   = chsweep_q;
    asc_d       = asc_q;
    max_d       = max_q;
    code_d      = code_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    data_d      = '0;
    data_en_d   = 1'b0;
    load_d      = 1'b0;
    acq_start_d = 1'b0;
    acq_stop_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          start_dac_d = bus.StartDAC;
          stop_dac_d  = bus.StopDAC;
          step_d      = (bus.StepDAC == '0) ? DAC_WIDTH'(1) : bus.StepDAC;
          sel_d       = (bus.DacSelect == 2'd3) ? 2'd0 : bus.DacSelect;
          chsweep_d   = bus.ChannelSweep;
          asc_d       = (bus.StartDAC <= bus.StopDAC);
          max_d       = bus.MaxPackageNumber;
          code_d      = bus.StartDAC;
          ch_d        = bus.ChannelSweep ? '0 : bus.SingleChannel;
          state_d     = StHeader;
        end
      end
      StHeader: begin
        data_d    = 16'hFF45;
        data_en_d = 1'b1;
        state_d   = StParamA;
      end
      StParamA: begin
        data_d    = {4'hA, sel_q, code10};
        data_en_d = 1'b1;
        state_d   = StParamB;
      end
      StParamB: begin
        data_d    = {4'hC, 6'b0, ch6};
        data_en_d = 1'b1;
        state_d   = StLoadSc;
      end
      StLoadSc: begin
        load_d  = 1'b1;
        state_d = StWaitLoad;
      end
      StWaitLoad: begin
        if (bus.LoadDone) state_d = StStartAcq;
      end
      StStartAcq: begin
        cnt_d = '0;
        if (max_q == '0) begin
          state_d = StNextPoint;
        end else begin
          acq_start_d = 1'b1;
          state_d     = StAcq;
        end
      end
      StAcq: begin
        if (bus.ParallelData_en) begin
          data_d    = bus.ParallelData;
          data_en_d = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc == max_q) begin
            acq_stop_d = 1'b1;
            state_d    = StNextPoint;
          end
        end
      end
      StNextPoint: begin
        if (remain >= step_q) begin
          code_d  = asc_q ? (code_q + step_q) : (code_q - step_q);
          state_d = StParamA;
        end else if (chsweep_q && (ch_q < LastCh)) begin
          ch_d    = ch_q + 1'b1;
          code_d  = start_dac_q;
          state_d = StParamA;
        end else begin
          state_d = StTail;
        end
      end
      StTail: begin
        data_d    = 16'hFF55;
        data_en_d = 1'b1;
        state_d   = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides whatever the current state decided, including strobes and LoadDone.
    if (abort) begin
      state_d     = StTail;
      code_d      = code_q;
      ch_d        = ch_q;
      cnt_d       = cnt_q;
      data_d      = '0;
      data_en_d   = 1'b0;
      load_d      = 1'b0;
      acq_start_d = 1'b0;
      acq_stop_d  = (state_q == StAcq);
    end
  end

  // State, configuration and output registers; the edge detector resets high so a start
  // level held through reset does not launch a sweep.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      sweep_start_q <= 1'b1;
      start_dac_q   <= '0;
      stop_dac_q    <= '0;
      step_q        <= '0;
      sel_q         <= '0;
      chsweep_q     <= 1'b0;
      asc_q         <= 1'b0;
      max_q         <= '0;
      code_q        <= '0;
      ch_q          <= '0;
      cnt_q         <= '0;
      data_q        <= '0;
      data_en_q     <= 1'b0;
      load_q        <= 1'b0;
      acq_start_q   <= 1'b0;
      acq_stop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_start_q <= bus.SweepStart;
      start_dac_q   <= start_dac_d;
      stop_dac_q    <= stop_dac_d;
      step_q        <= step_d;
      sel_q         <= sel_d;
      chsweep_q     <= chsweep_d;
      asc_q         <= asc_d;
      max_q         <= max_d;
      code_q        <= code_d;
      ch_q          <= ch_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      data_en_q     <= data_en_d;
      load_q        <= load_d;
      acq_start_q   <= acq_start_d;
      acq_stop_q    <= acq_stop_d;
    end
  end

  // The SC chain shifts the DAC code LSB-first, so present it bit-reversed.
  always_comb begin
    bus.OutDAC = '0;
    for (int i = 0; i < int'(DAC_WIDTH); i++) begin
      bus.OutDAC[i] = code_q[DAC_WIDTH-1-i];
    end
  end

  assign bus.OutDACSelect    = sel_q;
  assign bus.MaskChannel     = ch_q;
  assign bus.ACQDone         = (state_q == StDone);
  assign bus.SweepACQData    = data_q;
  assign bus.SweepACQData_en = data_en_q;
  assign bus.LoadSCParameter = load_q;
  assign bus.SingleACQStart  = acq_start_q;
  assign bus.SingleACQStop   = acq_stop_q;
endmodule

// File: tb/tb_sweep_scan_engine.sv
// Scoreboard bench for sweep_scan_engine: the stimulus side pushes the expected output stream
// from a plain-arithmetic sweep model, a negedge monitor pops and compares.
module tb_sweep_scan_engine;
  localparam int unsigned DW  = 10;
  localparam int unsigned CHN = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned CHW = $clog2(CHN);

  typedef enum int {KHdr, KParA, KParB, KData, KTail} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] word;
  } exp_t;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sweep_scan_engine_if #(.DAC_WIDTH(DW), .CH_NUM(CHN), .CNT_WIDTH(CW)) bus ();

  sweep_scan_engine #(.DAC_WIDTH(DW), .CH_NUM(CHN), .CNT_WIDTH(CW)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_load = 0;
  int   n_start = 0;
  int   n_stop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [9:0] bitrev(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  function automatic void push(input kind_e k, input logic [15:0] w);
    exp_t e;
    e.kind = k;
    e.word = w;
    exp_q.push_back(e);
  endfunction

  // Monitor: counts pulses and checks every presented stream word against the scoreboard.
  always @(negedge Clk) begin
    if (reset_n) begin
      if (bus.LoadSCParameter) n_load++;
      if (bus.SingleACQStart)  n_start++;
      if (bus.SingleACQStop)   n_stop++;
      if (bus.SweepACQData_en) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h, required no output (t=%0t)",
                   bus.SweepACQData, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("stream_word", 32'(bus.SweepACQData), 32'(e.word));
          if (e.kind == KParA) begin
            check("OutDAC", 32'(bus.OutDAC), 32'(bitrev(e.word[9:0])));
            check("OutDACSelect", 32'(bus.OutDACSelect), 32'(e.word[11:10]));
          end
          if (e.kind == KParB) check("MaskChannel", 32'(bus.MaskChannel), 32'(e.word[5:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // which: 0 = LoadSCParameter, 1 = SingleACQStart, 2 = ACQDone.
  task automatic wait_sig(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if ((which == 0 && bus.LoadSCParameter) || (which == 1 && bus.SingleACQStart) ||
          (which == 2 && bus.ACQDone)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic scramble_cfg();
    bus.StartDAC         = DW'($urandom);
    bus.StopDAC          = DW'($urandom);
    bus.StepDAC          = DW'($urandom);
    bus.DacSelect        = 2'($urandom);
    bus.ChannelSweep     = 1'($urandom);
    bus.SingleChannel    = CHW'($urandom);
    bus.MaxPackageNumber = CW'($urandom);
  endtask

  task automatic start_sweep(input int start, input int stop, input int step, input int sel,
                             input int chsw, input int single, input int maxp);
    bus.SweepStart = 1'b0;
    tick();
    bus.StartDAC         = DW'(start);
    bus.StopDAC          = DW'(stop);
    bus.StepDAC          = DW'(step);
    bus.DacSelect        = 2'(sel);
    bus.ChannelSweep     = 1'(chsw);
    bus.SingleChannel    = CHW'(single);
    bus.MaxPackageNumber = CW'(maxp);
    bus.SweepStart       = 1'b1;
    tick();
    // Config must have been captured on the edge; anything later is noise.
    scramble_cfg();
    bus.SweepStart = 1'b0;
    check("acq_done_cleared_on_start", 32'(bus.ACQDone), 32'd0);
  endtask

  // abort_after < 0: no abort; otherwise abort together with the strobe of that package index.
  task automatic run_sweep(input int start, input int stop, input int step, input int sel,
                           input int chsw, input int single, input int maxp,
                           input int abort_after);
    int   s, c, diff, pts, b_load, b_start, b_stop;
    int   codes[$];
    int   chans[$];
    bit   ok, aborted;
    logic [9:0]  c10;
    logic [5:0]  ch6;
    logic [1:0]  s2;
    logic [15:0] d;

    s = (step == 0) ? 1 : step;
    c = start;
    forever begin
      codes.push_back(c);
      diff = (start <= stop) ? stop - c : c - stop;
      if (diff >= s) c = (start <= stop) ? c + s : c - s;
      else break;
    end
    if (chsw != 0) for (int i = 0; i < int'(CHN); i++) chans.push_back(i);
    else chans.push_back(single);
    s2 = (sel == 3) ? 2'd0 : 2'(sel);

    b_load = n_load; b_start = n_start; b_stop = n_stop;
    pts = 0; aborted = 1'b0;
    push(KHdr, 16'hFF45);
    start_sweep(start, stop, step, sel, chsw, single, maxp);

    foreach (chans[ci]) begin
      foreach (codes[k]) begin
        c10 = 10'(codes[k]);
        ch6 = 6'(chans[ci]);
        push(KParA, {4'hA, s2, c10});
        push(KParB, {4'hC, 6'b0, ch6});
        pts++;
        wait_sig(0, 40, ok);
        check("load_sc_seen", 32'(ok), 32'd1);
        if (!ok) begin aborted = 1'b1; break; end
        // A start edge while waiting for the loader must be ignored.
        bus.SweepStart = 1'b1;
        tick();
        bus.SweepStart = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        bus.LoadDone = 1'b1;
        tick();
        bus.LoadDone = 1'b0;
        if (maxp > 0) begin
          wait_sig(1, 10, ok);
          check("acq_start_seen", 32'(ok), 32'd1);
          if (!ok) begin aborted = 1'b1; break; end
          for (int j = 0; j < maxp; j++) begin
            repeat ($urandom_range(0, 2)) tick();
            d = 16'($urandom);
            bus.ParallelData    = d;
            bus.ParallelData_en = 1'b1;
            if (j == abort_after) begin
              bus.SweepAbort = 1'b1;
              tick();
              bus.SweepAbort      = 1'b0;
              bus.ParallelData_en = 1'b0;
              aborted = 1'b1;
              break;
            end
            push(KData, d);
            tick();
            bus.ParallelData_en = 1'b0;
          end
          if (!aborted) begin
            // Strobe after the last package of a point is dropped.
            bus.ParallelData    = 16'($urandom);
            bus.ParallelData_en = 1'b1;
            tick();
            bus.ParallelData_en = 1'b0;
          end
        end
        if (aborted) break;
      end
      if (aborted) break;
    end

    push(KTail, 16'hFF55);
    wait_sig(2, 100, ok);
    check("acq_done", 32'(ok), 32'd1);
    tick();
    check("acq_done_level", 32'(bus.ACQDone), 32'd1);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    if (abort_after < 0) check("points", 32'(n_load - b_load), 32'(codes.size() * chans.size()));
    else check("points_before_abort", 32'(n_load - b_load), 32'(pts));
    check("acq_start_pulses", 32'(n_start - b_start), 32'((maxp > 0) ? pts : 0));
    check("acq_stop_pulses", 32'(n_stop - b_stop), 32'((maxp > 0) ? pts : 0));
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_OutDAC"}, 32'(bus.OutDAC), 32'd0);
    check({tag, "_MaskChannel"}, 32'(bus.MaskChannel), 32'd0);
    check({tag, "_OutDACSelect"}, 32'(bus.OutDACSelect), 32'd0);
    check({tag, "_ACQDone"}, 32'(bus.ACQDone), 32'd0);
    check({tag, "_data_en"}, 32'(bus.SweepACQData_en), 32'd0);
    check({tag, "_data"}, 32'(bus.SweepACQData), 32'd0);
    check({tag, "_load"}, 32'(bus.LoadSCParameter), 32'd0);
    check({tag, "_acq_start"}, 32'(bus.SingleACQStart), 32'd0);
    check({tag, "_acq_stop"}, 32'(bus.SingleACQStop), 32'd0);
  endtask

  task automatic reset_mid_sweep();
    bit ok;
    int b_load;
    push(KHdr, 16'hFF45);
    push(KParA, {4'hA, 2'd2, 10'd1});
    push(KParB, {4'hC, 6'b0, 6'd2});
    start_sweep(1, 9, 3, 2, 0, 2, 2);
    wait_sig(0, 40, ok);
    check("reset_test_load_seen", 32'(ok), 32'd1);
    check("OutDAC_code1", 32'(bus.OutDAC), 32'h200);
    bus.SweepStart = 1'b1;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    b_load = n_load;
    // Start level held across reset release must not launch a sweep.
    repeat (10) tick();
    check("held_start_no_sweep_done", 32'(bus.ACQDone), 32'd0);
    check("held_start_no_load", 32'(n_load - b_load), 32'd0);
    bus.SweepStart = 1'b0;
    tick();
  endtask

  initial begin
    int st, sp, span, mx, ab;
    bus.SweepStart      = 1'b0;
    bus.SweepAbort      = 1'b0;
    bus.ParallelData    = '0;
    bus.ParallelData_en = 1'b0;
    bus.LoadDone        = 1'b0;
    scramble_cfg();
    repeat (3) tick();
    check_all_zero("reset_state");
    reset_n = 1'b1;
    repeat (2) tick();

    run_sweep(100, 104, 2, 1, 0, 3, 3, -1);  // ascending, three points
    run_sweep(10, 3, 4, 2, 0, 1, 2, -1);     // descending, stops at 6
    run_sweep(7, 7, 1, 0, 1, 0, 1, -1);      // one point per channel
    run_sweep(20, 26, 3, 3, 1, 0, 0, -1);    // no acquisition, DacSelect 3 -> 0
    run_sweep(1, 1, 5, 1, 0, 3, 1, -1);      // OutDAC 0x200
    run_sweep(5, 8, 0, 2, 0, 2, 1, -1);      // step 0 behaves as 1
    run_sweep(50, 60, 5, 0, 0, 2, 5, 1);     // abort on second package

    for (int n = 0; n < 6; n++) begin
      st   = int'($urandom_range(0, 1023));
      span = int'($urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) sp = (st + span > 1023) ? 1023 : st + span;
      else sp = (st - span < 0) ? 0 : st - span;
      mx = int'($urandom_range(0, 3));
      ab = (mx > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, mx - 1)) : -1;
      run_sweep(st, sp, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, CHN - 1)), mx, ab);
    end

    reset_mid_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
